// File: rtl/calc_enc_seq.sv
// Button front end for the calculator: synchronises and debounces the board buttons,
// encodes the l/r/d levels to an ALU opcode, and commits it over a valid/ack handshake.
module calc_enc_seq #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       btnl,
  input  logic       btnr,
  input  logic       btnd,
  input  logic       btnc,
  input  logic       op_ack,
  output logic [3:0] alu_op_live,
  output logic [3:0] alu_op,
  output logic       op_valid,
  output logic       op_overrun
);

  // state   | meaning
  // IDLE    | no opcode pending, waiting for a commit press
  // PENDING | alu_op captured and offered, waiting for op_ack
  typedef enum logic {IDLE, PENDING} state_t;

  localparam int              NB       = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit order everywhere: 3 = c, 2 = l, 1 = r, 0 = d.
  logic [NB-1:0] w_raw;
  logic [NB-1:0] w_stable;

  assign w_raw = {btnc, btnl, btnr, btnd};

  for (genvar b = 0; b < NB; b++) begin : g_btn
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_stable;
    logic [CNT_W-1:0]       r_cnt;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        r_sync   <= '0;
        r_stable <= 1'b0;
        r_cnt    <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[b]};
        if (r_sync[SYNC_STAGES-1] == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt >= CNT_LAST) begin
          // >= keeps the counter from ever wrapping
          r_stable <= r_sync[SYNC_STAGES-1];
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end

    assign w_stable[b] = r_stable;
  end

  function automatic logic [3:0] f_encode(input logic [2:0] lrd);
    logic [3:0] op;
    case (lrd)
      3'b000:  op = 4'b0000;
      3'b001:  op = 4'b0001;
      3'b010:  op = 4'b0100;
      3'b011:  op = 4'b0101;
      3'b100:  op = 4'b0110;
      3'b101:  op = 4'b1010;
      3'b110:  op = 4'b1011;
      default: op = 4'b1100;
    endcase
    return op;
  endfunction

  logic [3:0] w_op_cur;
  logic       w_commit;
  logic       r_c_d;
  logic [3:0] r_live;
  logic [3:0] r_alu_op;
  logic [3:0] w_alu_op_nxt;
  logic       r_ovr;
  logic       w_ovr_nxt;
  state_t     r_state;
  state_t     w_state_nxt;

  assign w_op_cur = f_encode(w_stable[2:0]);
  assign w_commit = w_stable[3] & ~r_c_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_c_d    <= 1'b0;
      r_live   <= 4'b0000;
      r_alu_op <= 4'b0000;
      r_ovr    <= 1'b0;
      r_state  <= IDLE;
    end else begin
      r_c_d    <= w_stable[3];
      r_live   <= w_op_cur;
      r_alu_op <= w_alu_op_nxt;
      r_ovr    <= w_ovr_nxt;
      r_state  <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_alu_op_nxt = r_alu_op;
    w_ovr_nxt    = r_ovr;
    case (r_state)
      IDLE: begin
        if (w_commit) begin
          w_alu_op_nxt = w_op_cur;
          w_state_nxt  = PENDING;
        end
      end
      PENDING: begin
        if (w_commit) begin
          // a commit with a same-cycle ack is a clean back-to-back accept
          w_alu_op_nxt = w_op_cur;
          if (!op_ack) w_ovr_nxt = 1'b1;
        end else if (op_ack) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign alu_op_live = r_live;
  assign alu_op      = r_alu_op;
  assign op_valid    = (r_state == PENDING);
  assign op_overrun  = r_ovr;

endmodule

// File: tb/tb_calc_enc_seq.sv
// Bench for calc_enc_seq: cycle-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_calc_enc_seq;
  localparam int SS     = 2;
  localparam int DC     = 16;
  localparam int CW     = 16;
  localparam int SETTLE = SS + DC + 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic btnl = 1'b0, btnr = 1'b0, btnd = 1'b0, btnc = 1'b0, op_ack = 1'b0;
  logic [3:0] alu_op_live, alu_op;
  logic op_valid, op_overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  calc_enc_seq #(.SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn),
    .btnl(btnl), .btnr(btnr), .btnd(btnd), .btnc(btnc),
    .op_ack(op_ack),
    .alu_op_live(alu_op_live), .alu_op(alu_op),
    .op_valid(op_valid), .op_overrun(op_overrun)
  );

  // Opcode table indexed by {l,r,d}.
  logic [3:0] enc_tab [8] = '{4'b0000, 4'b0001, 4'b0100, 4'b0101,
                              4'b0110, 4'b1010, 4'b1011, 4'b1100};

  // Reference model: delay line for the synchroniser; a level flips once the
  // last DC synchronised samples all disagreed with it.
  logic [SS-1:0] m_sync [4];
  logic [DC-1:0] m_hist [4];
  logic [3:0]    m_stable;
  logic          m_c_d;
  logic [3:0]    m_live, m_op;
  logic          m_pend, m_ovr;

  always @(posedge clk or negedge resetn) begin : model
    logic [3:0] raw, s_old, st_old;
    logic       ev;
    if (!resetn) begin
      for (int b = 0; b < 4; b++) begin
        m_sync[b] = '0;
        m_hist[b] = '0;
      end
      m_stable = '0; m_c_d = 1'b0; m_live = '0; m_op = '0; m_pend = 1'b0; m_ovr = 1'b0;
    end else begin
      raw    = {btnc, btnl, btnr, btnd};
      st_old = m_stable;
      for (int b = 0; b < 4; b++) s_old[b] = m_sync[b][SS-1];
      ev     = st_old[3] && !m_c_d;
      m_live = enc_tab[st_old[2:0]];
      m_c_d  = st_old[3];
      if (ev) begin
        if (m_pend && !op_ack) m_ovr = 1'b1;
        m_pend = 1'b1;
        m_op   = enc_tab[st_old[2:0]];
      end else if (m_pend && op_ack) begin
        m_pend = 1'b0;
      end
      for (int b = 0; b < 4; b++) begin
        m_hist[b] = {m_hist[b][DC-2:0], s_old[b]};
        if (m_hist[b] == {DC{~st_old[b]}}) m_stable[b] = ~st_old[b];
        m_sync[b] = {m_sync[b][SS-2:0], raw[b]};
      end
    end
  end

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      chk("model alu_op_live", alu_op_live, m_live);
      chk("model op_valid", {3'b0, op_valid}, {3'b0, m_pend});
      if (m_pend) chk("model alu_op", alu_op, m_op);
      chk("model op_overrun", {3'b0, op_overrun}, {3'b0, m_ovr});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_lrd(input logic [2:0] v);
    {btnl, btnr, btnd} = v;
  endtask

  logic [2:0] sweep_in  [8] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b000};
  logic [3:0] sweep_exp [8] = '{4'b0001, 4'b0100, 4'b0101, 4'b0110, 4'b1010, 4'b1011, 4'b1100, 4'b0000};

  initial begin
    logic [3:0] prev;
    tick(3);
    chk("reset alu_op_live", alu_op_live, 4'b0000);
    chk("reset alu_op", alu_op, 4'b0000);
    chk("reset op_valid", {3'b0, op_valid}, 4'b0000);
    chk("reset op_overrun", {3'b0, op_overrun}, 4'b0000);
    resetn = 1'b1;
    tick(2);

    prev = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      set_lrd(sweep_in[i]);
      tick(SS + DC);
      chk("sweep live before latency", alu_op_live, prev);
      tick(1);
      chk("sweep live at latency", alu_op_live, sweep_exp[i]);
      prev = sweep_exp[i];
      tick(2);
    end

    for (int k = 0; k < 10; k++) begin
      btnl = 1'b1; tick(5);
      btnl = 1'b0; tick(5);
    end
    chk("bounce live unchanged", alu_op_live, 4'b0000);
    btnl = 1'b1;
    tick(SS + DC);
    chk("bounce steady before latency", alu_op_live, 4'b0000);
    tick(1);
    chk("bounce steady live", alu_op_live, 4'b0110);
    btnl = 1'b0;
    tick(SETTLE);

    set_lrd(3'b110);
    tick(SETTLE);
    btnc = 1'b1;
    tick(SS + DC);
    chk("commit valid before latency", {3'b0, op_valid}, 4'b0000);
    tick(1);
    chk("commit valid", {3'b0, op_valid}, 4'b0001);
    chk("commit alu_op", alu_op, 4'b1011);
    tick(7);
    chk("commit alu_op held", alu_op, 4'b1011);
    op_ack = 1'b1;
    tick(1);
    op_ack = 1'b0;
    chk("ack drops valid", {3'b0, op_valid}, 4'b0000);
    tick(200 - (SS + DC + 1) - 8);
    chk("held btnc no second event", {3'b0, op_valid}, 4'b0000);
    btnc = 1'b0;
    tick(SETTLE);
    chk("release no event", {3'b0, op_valid}, 4'b0000);

    set_lrd(3'b100);
    tick(SETTLE);
    btnc = 1'b1;
    tick(SS + DC + 1);
    chk("b2b first alu_op", alu_op, 4'b0110);
    btnc = 1'b0;
    tick(SETTLE);
    set_lrd(3'b101);
    tick(SETTLE);
    btnc = 1'b1;
    tick(SS + DC);
    op_ack = 1'b1;
    tick(1);
    op_ack = 1'b0;
    chk("b2b new alu_op", alu_op, 4'b1010);
    chk("b2b valid stays", {3'b0, op_valid}, 4'b0001);
    chk("b2b no overrun", {3'b0, op_overrun}, 4'b0000);
    op_ack = 1'b1;
    tick(1);
    op_ack = 1'b0;
    chk("b2b ack clears", {3'b0, op_valid}, 4'b0000);
    btnc = 1'b0;
    tick(SETTLE);

    set_lrd(3'b001);
    tick(SETTLE);
    btnc = 1'b1;
    tick(SS + DC + 1);
    chk("ovr first alu_op", alu_op, 4'b0001);
    btnc = 1'b0;
    tick(SETTLE);
    set_lrd(3'b011);
    tick(SETTLE);
    btnc = 1'b1;
    tick(SS + DC + 1);
    chk("ovr new alu_op", alu_op, 4'b0101);
    chk("ovr valid stays", {3'b0, op_valid}, 4'b0001);
    chk("ovr flag set", {3'b0, op_overrun}, 4'b0001);
    btnc = 1'b0;
    tick(SETTLE);
    op_ack = 1'b1;
    tick(1);
    op_ack = 1'b0;
    chk("ovr ack clears valid", {3'b0, op_valid}, 4'b0000);
    chk("ovr sticky after ack", {3'b0, op_overrun}, 4'b0001);
    tick(3);
    btnc = 1'b1;
    tick(SS + DC + 1);
    chk("pre-reset valid", {3'b0, op_valid}, 4'b0001);

    #2 resetn = 1'b0;
    #1;
    chk("async reset op_valid", {3'b0, op_valid}, 4'b0000);
    chk("async reset alu_op", alu_op, 4'b0000);
    chk("async reset op_overrun", {3'b0, op_overrun}, 4'b0000);
    chk("async reset live", alu_op_live, 4'b0000);
    btnc = 1'b0;
    set_lrd(3'b000);
    tick(2);
    resetn = 1'b1;
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/calc_enc_seq.md
Name: calc_enc_seq

Overview:
- Sequential, parametrised successor to the combinational button-to-opcode encoder.
- Synchronises and debounces the raw board buttons btnl, btnr and btnd, and continuously encodes the stable levels into a 4-bit ALU opcode.
- On a debounced press of the commit button btnc, it captures the opcode and presents it to the calculator datapath over a valid/ack handshake.
- Sits between the board button pins and the ALU/accumulator control.

Parameters:
- SYNC_STAGES, 2, number of flip-flop stages in each input synchroniser; minimum 2.
- DEBOUNCE_CYCLES, 16, number of consecutive cycles a synchronised input must differ from its stable value before the stable value flips; minimum 1.
- CNT_W, 16, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state is on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- btnl  input  1  raw left button, asynchronous to clk.
- btnr  input  1  raw right button, asynchronous to clk.
- btnd  input  1  raw down button, asynchronous to clk.
- btnc  input  1  raw commit button, asynchronous to clk.
- op_ack  input  1  consumer accepts the pending opcode.
- alu_op_live  output  4  registered encoding of the current stable l/r/d levels.
- alu_op  output  4  captured opcode; valid while op_valid is 1.
- op_valid  output  1  a captured opcode is pending.
- op_overrun  output  1  sticky flag: a commit arrived while an opcode was pending.

Behaviour:
- Reset (resetn=0, asynchronous):
  - all synchroniser flip-flops, stable levels and debounce counters clear to 0;
  - alu_op_live=0000, alu_op=0000, op_valid=0, op_overrun=0;
  - FSM enters IDLE.
  - Reset asserted mid-handshake discards the pending opcode with no other side effect.
- Synchronisers: each raw button passes through SYNC_STAGES flip-flops, giving the signal s_x.
- Debounce, per button x:
  - If s_x equals stable_x, cnt_x is cleared to 0.
  - Otherwise cnt_x increments each cycle.
  - When cnt_x reaches DEBOUNCE_CYCLES-1 while s_x still differs, stable_x takes s_x on the next edge and cnt_x clears.
  - Any single-cycle return of s_x to stable_x restarts the count.
  - The counter never wraps.
- Press latency: a clean raw step becomes stable after SYNC_STAGES+DEBOUNCE_CYCLES cycles.
- Encoding, stable {l,r,d} to opcode; this table is normative:
  - 000→0000
  - 001→0001
  - 010→0100
  - 011→0101
  - 100→0110
  - 101→1010
  - 110→1011
  - 111→1100
- alu_op_live is the registered encoding of the stable levels, one cycle behind them.
- Commit event: a stable_c transition from 0 to 1, detected against a one-cycle-delayed copy. Holding btnc produces exactly one event; its release produces none.
- FSM:
  - IDLE: on a commit event, alu_op ← encode(stable l,r,d of the same cycle), op_valid←1 on the next edge, go to PENDING.
  - PENDING: op_valid=1 and alu_op is held stable.
    - op_ack=1 with no commit: op_valid←0, go to IDLE.
    - Commit and op_ack=1 in the same cycle: the new opcode is captured, op_valid stays 1, FSM stays in PENDING, op_overrun is unchanged (back-to-back accept).
    - Commit with op_ack=0: alu_op is overwritten with the new encoding, op_overrun←1, FSM stays in PENDING.
  - op_ack while IDLE is ignored.
- op_overrun clears only on reset.
- Commit-to-op_valid latency after the stable press: 1 cycle. Total from raw btnc step: SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles.

Test Plan:
- Reset with all buttons at 0: all outputs 0. Assert resetn=0 while op_valid=1: op_valid, alu_op and op_overrun go to 0 immediately, without waiting for a clock edge.
- Sweep {l,r,d} through all 8 codes with clean steps: alu_op_live matches the table, e.g. 101→1010 and 111→1100, each exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles after the raw step.
- Bounce: toggle btnl with high pulses shorter than DEBOUNCE_CYCLES (e.g. 5 cycles with the default) for 10 bursts, then hold steady: stable_l changes only after the final steady interval, and alu_op_live never glitches.
- Commit handshake: l,r,d=110, press btnc and hold for 200 cycles → one op_valid pulse train with alu_op=1011. op_ack after 7 cycles → op_valid falls on the next edge, and no second event occurs while btnc stays held.
- Overrun: first commit with 001 (alu_op=0001), then without ack change to 011 and commit again → alu_op=0101, op_valid stays 1, op_overrun=1 and remains 1 after ack.
- Simultaneous commit and op_ack in PENDING → new alu_op captured, op_valid stays 1, op_overrun stays 0.
